// File: rtl/time_pkg.sv
// Shared types, state encoding and BCD digit limits for the time_keeper clock.
// Also holds the 24h -> 12h display conversion used when TIME_KEEPER_12H_EN is defined.
package time_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_e;

    localparam bcd_t SEC1_MAX       = 4'd5;
    localparam bcd_t MIN1_MAX       = 4'd5;
    localparam bcd_t H1_MAX         = 4'd2;
    localparam bcd_t H0_MAX_AT_H1_2 = 4'd3;
    localparam bcd_t DIGIT_MAX      = 4'd9;

    typedef struct packed {
        bcd_t h1;
        bcd_t h0;
        logic pm;
    } hour_disp_t;

    // Map a legal 24-hour BCD hour (00..23) onto 12-hour display digits plus a PM flag.
    function automatic hour_disp_t to_12h(input bcd_t h1, input bcd_t h0);
        logic [4:0] hv;
        logic [4:0] dh;
        hour_disp_t r;
        hv   = 5'(h1) * 5'd10 + 5'(h0);
        r.pm = (hv >= 5'd12);
        if (hv == 5'd0) begin
            dh = 5'd12;
        end else if (hv > 5'd12) begin
            dh = hv - 5'd12;
        end else begin
            dh = hv;
        end
        r.h1 = (dh >= 5'd10) ? 4'd1 : 4'd0;
        r.h0 = (dh >= 5'd10) ? 4'(dh - 5'd10) : 4'(dh);
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counter wrapping at MAX; load has priority over enable.
// carry_out flags the enabled step that wraps the digit back to zero.
module bcd_digit_counter
    import time_pkg::*;
#(
    parameter bcd_t MAX = DIGIT_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic load,
    input  bcd_t load_val,
    output bcd_t q,
    output logic carry_out
);

    bcd_t q_q;
    bcd_t q_d;

    // NOTE: next-state logic assigns its default first, so no path can infer a latch.
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d = (q_q == MAX) ? 4'd0 : q_q + 4'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 4'd0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q         = q_q;
    assign carry_out = en && (q_q == MAX);

endmodule

// File: rtl/time_keeper.sv
// Free-running BCD hh:mm:ss counter with a load port, pause, and per-second prescaler.
// Define TIME_KEEPER_12H_EN to present hours in 12-hour format with a registered pm flag.
module time_keeper
    import time_pkg::*;
#(
    parameter int unsigned CLK_PER_SEC = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  bcd_t h1_in,
    input  bcd_t h0_in,
    input  bcd_t min1_in,
    input  bcd_t min0_in,
    input  logic pause,
    output bcd_t h1,
    output bcd_t h0,
    output bcd_t min1,
    output bcd_t min0,
    output bcd_t sec1,
    output bcd_t sec0,
    output logic pm,
    output logic running,
    output logic sec_pulse,
    output logic day_wrap,
    output logic load_err
);

    localparam int unsigned        PRESC_W    = $clog2(CLK_PER_SEC);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_SEC - 1);

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    bcd_t               h1_q, h1_d, h0_q, h0_d;
    logic               sec_pulse_q, day_wrap_q, load_err_q;
    logic               load_bad, load_ok, tick, hour_wrap;
    logic               c_s0, c_s1, c_m0, c_m1;

    assign load_bad = (h1_in > H1_MAX)
                   || ((h1_in == H1_MAX) && (h0_in > H0_MAX_AT_H1_2))
                   || (h0_in > DIGIT_MAX)
                   || (min1_in > MIN1_MAX)
                   || (min0_in > DIGIT_MAX);
    assign load_ok  = load && !load_bad;

    // An accepted load on the wrap cycle discards that tick entirely.
    assign tick      = (state_q == RUNNING) && !pause && (presc_q == PRESC_LAST) && !load_ok;
    assign hour_wrap = c_m1 && (h1_q == H1_MAX) && (h0_q == H0_MAX_AT_H1_2);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        if (load_ok) begin
            state_d = RUNNING;
            presc_d = '0;
        end else if (state_q == STOPPED) begin
            presc_d = '0;
        end else if (!pause) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
        end
    end

    // Hours are kept as a pair here because 23 -> 00 couples both digits.
    always_comb begin
        h1_d = h1_q;
        h0_d = h0_q;
        if (load_ok) begin
            h1_d = h1_in;
            h0_d = h0_in;
        end else if (c_m1) begin
            if (hour_wrap) begin
                h1_d = 4'd0;
                h0_d = 4'd0;
            end else if (h0_q == DIGIT_MAX) begin
                h1_d = h1_q + 4'd1;
                h0_d = 4'd0;
            end else begin
                h0_d = h0_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= STOPPED;
            presc_q     <= '0;
            h1_q        <= 4'd0;
            h0_q        <= 4'd0;
            sec_pulse_q <= 1'b0;
            day_wrap_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            h1_q        <= h1_d;
            h0_q        <= h0_d;
            sec_pulse_q <= tick;
            day_wrap_q  <= hour_wrap;
            load_err_q  <= load && load_bad;
        end
    end

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_sec0 (
        .clk(clk), .reset(reset), .en(tick), .load(load_ok), .load_val(4'd0),
        .q(sec0), .carry_out(c_s0)
    );

    bcd_digit_counter #(.MAX(SEC1_MAX)) u_sec1 (
        .clk(clk), .reset(reset), .en(c_s0), .load(load_ok), .load_val(4'd0),
        .q(sec1), .carry_out(c_s1)
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min0 (
        .clk(clk), .reset(reset), .en(c_s1), .load(load_ok), .load_val(min0_in),
        .q(min0), .carry_out(c_m0)
    );

    bcd_digit_counter #(.MAX(MIN1_MAX)) u_min1 (
        .clk(clk), .reset(reset), .en(c_m0), .load(load_ok), .load_val(min1_in),
        .q(min1), .carry_out(c_m1)
    );

`ifdef TIME_KEEPER_12H_EN
    // Display hours are converted from next-state so they update on the same edge as the digits.
    hour_disp_t disp_d;
    bcd_t       disp_h1_q, disp_h0_q;
    logic       pm_q;

    assign disp_d = to_12h(h1_d, h0_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_h1_q <= 4'd0;
            disp_h0_q <= 4'd0;
            pm_q      <= 1'b0;
        end else begin
            disp_h1_q <= disp_d.h1;
            disp_h0_q <= disp_d.h0;
            pm_q      <= disp_d.pm;
        end
    end

    assign h1 = disp_h1_q;
    assign h0 = disp_h0_q;
    assign pm = pm_q;
`else
    assign h1 = h1_q;
    assign h0 = h0_q;
    assign pm = 1'b0;
`endif

    assign running   = (state_q == RUNNING);
    assign sec_pulse = sec_pulse_q;
    assign day_wrap  = day_wrap_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_time_keeper.sv
// Scoreboard bench for time_keeper with a 4-cycle second; expected pulses are queued
// by the stimulus and popped by an independent negedge monitor.
module tb_time_keeper;

    localparam int CPS = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] h1_in = 4'd0, h0_in = 4'd0, min1_in = 4'd0, min0_in = 4'd0;
    logic [3:0] h1, h0, min1, min0, sec1, sec0;
    logic       pm, running, sec_pulse, day_wrap, load_err;
    logic [23:0] dut_disp;

    time_keeper #(.CLK_PER_SEC(CPS)) dut (
        .clk(clk), .reset(reset), .load(load),
        .h1_in(h1_in), .h0_in(h0_in), .min1_in(min1_in), .min0_in(min0_in),
        .pause(pause),
        .h1(h1), .h0(h0), .min1(min1), .min0(min0), .sec1(sec1), .sec0(sec0),
        .pm(pm), .running(running), .sec_pulse(sec_pulse),
        .day_wrap(day_wrap), .load_err(load_err)
    );

    assign dut_disp = {h1, h0, min1, min0, sec1, sec0};

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          cyc;
        logic [23:0] disp;
        logic        pm;
        logic        dw;
    } exp_t;

    exp_t tick_q[$];
    int   err_q[$];
    exp_t mon_e;
    int   mon_c;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: second-of-day to displayed BCD digits.
    function automatic exp_t make_exp(input int sod, input int at, input logic dw);
        int   h, m, s;
        exp_t e;
        h    = sod / 3600;
        m    = (sod / 60) % 60;
        s    = sod % 60;
        e.pm = 1'b0;
`ifdef TIME_KEEPER_12H_EN
        e.pm = (h >= 12);
        if (h == 0) h = 12;
        else if (h > 12) h = h - 12;
`endif
        e.disp = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
        e.cyc  = at;
        e.dw   = dw;
        return e;
    endfunction

    always @(negedge clk) begin
        if (sec_pulse) begin
            if (tick_q.size() == 0) begin
                check("sec_pulse_unexpected", 32'(sec_pulse), 32'd0);
            end else begin
                mon_e = tick_q.pop_front();
                check("tick_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("tick_time", 32'({dut_disp, pm, day_wrap}), 32'({mon_e.disp, mon_e.pm, mon_e.dw}));
            end
        end else if (day_wrap) begin
            check("day_wrap_without_sec_pulse", 32'(day_wrap), 32'd0);
        end
        if (load_err) begin
            if (err_q.size() == 0) begin
                check("load_err_unexpected", 32'(load_err), 32'd0);
            end else begin
                mon_c = err_q.pop_front();
                check("load_err_cycle", 32'(cyc), 32'(mon_c));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_load(input int hh, input int mm, input bit expect_err, output int p);
        h1_in   = 4'(hh / 10);
        h0_in   = 4'(hh % 10);
        min1_in = 4'(mm / 10);
        min0_in = 4'(mm % 10);
        load    = 1'b1;
        p       = cyc;
        if (expect_err) err_q.push_back(p + 1);
        step();
        load    = 1'b0;
    endtask

    task automatic push_ticks(input int t0, input int p, input int n);
        int sod;
        for (int k = 1; k <= n; k++) begin
            sod = (t0 + k) % 86400;
            tick_q.push_back(make_exp(sod, p + 1 + CPS * k, sod == 0));
        end
    endtask

    task automatic check_time(input string name, input int sod, input logic run);
        exp_t e;
        e = make_exp(sod, 0, 1'b0);
        check(name, 32'({dut_disp, pm, running}), 32'({e.disp, e.pm, run}));
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (tick_q.size() == 0 && err_q.size() == 0) break;
            step();
        end
        if (tick_q.size() != 0 || err_q.size() != 0) begin
            check("drain_timeout", 32'(tick_q.size() + err_q.size()), 32'd0);
            tick_q.delete();
            err_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, q, t;

        repeat (3) step();
        reset = 1'b0;
        repeat (10) step();
        check("reset_state", 32'({dut_disp, pm, running, sec_pulse, day_wrap, load_err}), 32'd0);

        // First second after a load lands CPS cycles after the load becomes visible.
        t = 12 * 3600 + 34 * 60;
        do_load(12, 34, 1'b0, p);
        check_time("load_1234", t, 1'b1);
        push_ticks(t, p, 1);
        repeat (CPS) step();
        check_time("first_second_1234", t + 1, 1'b1);
        check("first_second_pulse", 32'(sec_pulse), 32'd1);
        step();
        check("sec_pulse_one_cycle", 32'(sec_pulse), 32'd0);
        drain(20);
        do_reset();

        // Full minute through the midnight rollover.
        t = 23 * 3600 + 59 * 60;
        do_load(23, 59, 1'b0, p);
        check_time("load_2359", t, 1'b1);
        push_ticks(t, p, 60);
        drain(400);
        check_time("wrap_to_midnight", 0, 1'b1);
        do_reset();

        // Rejected loads, both while stopped and while running.
        do_load(24, 0, 1'b1, p);
        check_time("err_while_stopped", 0, 1'b0);
        t = 5 * 3600 + 20 * 60;
        do_load(5, 20, 1'b0, p);
        push_ticks(t, p, 1);
        do_load(24, 0, 1'b1, q);
        check_time("err_2400_hold", t, 1'b1);
        step();
        do_load(9, 60, 1'b1, q);
        check_time("err_0960_hold", t, 1'b1);
        drain(40);
        do_reset();

        // Ten-cycle pause one cycle into a second delays the next advance by exactly ten.
        t = 10 * 3600;
        do_load(10, 0, 1'b0, p);
        tick_q.push_back(make_exp(t + 1, p + 5, 1'b0));
        tick_q.push_back(make_exp(t + 2, p + 19, 1'b0));
        tick_q.push_back(make_exp(t + 3, p + 23, 1'b0));
        repeat (5) step();
        pause = 1'b1;
        repeat (5) step();
        check_time("pause_frozen", t + 1, 1'b1);
        repeat (5) step();
        pause = 1'b0;
        drain(60);
        do_reset();

        // Load on the prescaler wrap cycle wins and the tick is dropped.
        do_load(10, 0, 1'b0, p);
        repeat (3) step();
        t = 7 * 3600 + 45 * 60;
        do_load(7, 45, 1'b0, q);
        check_time("load_on_tick", t, 1'b1);
        check("load_on_tick_no_pulse", 32'(sec_pulse), 32'd0);
        push_ticks(t, q, 1);
        drain(20);
        do_reset();

        // Hour display corners (12-hour mapping when compiled in).
        do_load(0, 15, 1'b0, p);
        check_time("hour_0015", 15 * 60, 1'b1);
        do_reset();
        do_load(13, 5, 1'b0, p);
        check_time("hour_1305", 13 * 3600 + 5 * 60, 1'b1);
        do_reset();
        repeat (4) step();
        drain(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
